smi_axi_slave_read_adaptor: RTL

- AXI-4 read slave port that converts each accepted AR burst into an SMI read request frame.
- Unpacks the returned SMI read response frame into AXI R beats.
- This is the mirror of the AXI read master adaptor. It lets an AXI master (e.g. a host or DMA bridge) reach memory through the SMI fabric.
- One transaction in flight; 64-bit data path; INCR bursts only.

---
 rtl/smi_axi_slave_read_adaptor_if.sv | 40 ++++
 rtl/smi_axi_slave_read_adaptor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/smi_axi_slave_read_adaptor_if.sv
// Bundle of the AXI read-slave channels (AR/R) and the SMI request/response
// flit streams seen by the slave read adaptor.
interface smi_axi_slave_read_adaptor_if #(
  parameter int AxiIdWidth = 4
);
  logic                  axiARValid;
  logic                  axiARReady;
  logic [AxiIdWidth-1:0] axiARId;
  logic [63:0]           axiARAddr;
  logic [7:0]            axiARLen;
  logic [3:0]            axiARCache;
  logic                  axiRValid;
  logic                  axiRReady;
  logic [AxiIdWidth-1:0] axiRId;
  logic [63:0]           axiRData;
  logic [1:0]            axiRResp;
  logic                  axiRLast;
  logic                  smiReqReady;
  logic [7:0]            smiReqEofc;
  logic [63:0]           smiReqData;
  logic                  smiReqStop;
  logic                  smiRespReady;
  logic [7:0]            smiRespEofc;
  logic [63:0]           smiRespData;
  logic                  smiRespStop;

  modport slave (
    input  axiARValid, axiARId, axiARAddr, axiARLen, axiARCache, axiRReady,
           smiReqStop, smiRespReady, smiRespEofc, smiRespData,
    output axiARReady, axiRValid, axiRId, axiRData, axiRResp, axiRLast,
           smiReqReady, smiReqEofc, smiReqData, smiRespStop
  );

  modport master (
    output axiARValid, axiARId, axiARAddr, axiARLen, axiARCache, axiRReady,
           smiReqStop, smiRespReady, smiRespEofc, smiRespData,
    input  axiARReady, axiRValid, axiRId, axiRData, axiRResp, axiRLast,
           smiReqReady, smiReqEofc, smiReqData, smiRespStop
  );
endinterface

// File: rtl/smi_axi_slave_read_adaptor.sv
// AXI-4 read slave that turns one INCR burst at a time into an SMI read request
// frame and unpacks the SMI response frame into 64-bit R beats.
module smi_axi_slave_read_adaptor #(
  parameter int          AxiIdWidth = 4,
  parameter logic [15:0] TagInit    = 16'h0000
) (
  input logic                         clk,
  input logic                         srst,
  smi_axi_slave_read_adaptor_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, REQ0, REQ1, RSP_HDR, RSP_DATA, RSP_PAD, RSP_LAST, DRAIN
  } stateT;

  stateT                 state;
  logic                  arReady;
  logic                  reqReady;
  logic [7:0]            reqEofc;
  logic [63:0]           reqData;
  logic                  respStop;
  logic                  rValid;
  logic [AxiIdWidth-1:0] rId;
  logic [63:0]           rData;
  logic [1:0]            rResp;
  logic                  rLast;
  logic [AxiIdWidth-1:0] idReg;
  logic [31:0]           addrHi;
  logic [7:0]            lenReg;
  logic [15:0]           tag;
  logic [15:0]           expTag;
  logic [1:0]            status;
  logic                  err;
  logic [31:0]           carry;
  logic [7:0]            beatCnt;
  logic [15:0]           byteLen;
  logic                  rFire;
  logic                  rFree;
  logic                  reqFire;
  logic                  respFire;
  logic                  finalBeat;
  logic                  frameEnd;
  logic                  unusedBits;

  assign byteLen   = ({8'd0, lenReg} + 16'd1) << 3;
  assign rFire     = rValid & bus.axiRReady;
  assign rFree     = ~rValid | bus.axiRReady;
  assign reqFire   = reqReady & ~bus.smiReqStop;
  assign respFire  = bus.smiRespReady & ~respStop;
  assign finalBeat = (beatCnt == lenReg);
  assign frameEnd  = (bus.smiRespEofc != 8'd0);
  assign unusedBits = ^{bus.axiARAddr[2:0], bus.axiARCache[3:1], bus.smiRespData[15:10]};

  // Response flits are only taken while the single R register can absorb a beat.
  always_comb begin
    respStop = 1'b1;
    case (state)
      RSP_HDR, DRAIN: respStop = 1'b0;
      RSP_DATA:       respStop = rValid & ~bus.axiRReady;
      default:        respStop = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= IDLE;
      arReady  <= 1'b0;
      reqReady <= 1'b0;
      reqEofc  <= 8'd0;
      reqData  <= 64'd0;
      rValid   <= 1'b0;
      rLast    <= 1'b0;
      tag      <= TagInit;
      err      <= 1'b0;
      beatCnt  <= 8'd0;
    end else begin
      if (rFire) rValid <= 1'b0;
      case (state)
        IDLE: begin
          if (arReady && bus.axiARValid) begin
            arReady  <= 1'b0;
            idReg    <= bus.axiARId;
            addrHi   <= bus.axiARAddr[63:32];
            lenReg   <= bus.axiARLen;
            expTag   <= tag;
            reqReady <= 1'b1;
            reqEofc  <= 8'd0;
            reqData  <= {bus.axiARAddr[31:3], 3'b000, tag, 7'd0, ~bus.axiARCache[0], 8'h02};
            state    <= REQ0;
          end else begin
            arReady <= 1'b1;
          end
        end
        REQ0: if (reqFire) begin
          reqData <= {16'd0, byteLen, addrHi};
          reqEofc <= 8'd8;
          state   <= REQ1;
        end
        REQ1: if (reqFire) begin
          reqReady <= 1'b0;
          reqEofc  <= 8'd0;
          tag      <= tag + 16'd1;
          state    <= RSP_HDR;
        end
        RSP_HDR: if (respFire) begin
          status  <= bus.smiRespData[9:8];
          err     <= (bus.smiRespData[7:0] != 8'hFD) || (bus.smiRespData[31:16] != expTag);
          carry   <= bus.smiRespData[63:32];
          beatCnt <= 8'd0;
          state   <= frameEnd ? RSP_PAD : RSP_DATA;
        end
        RSP_DATA: if (respFire) begin
          rValid  <= 1'b1;
          rId     <= idReg;
          rData   <= {bus.smiRespData[31:0], carry};
          carry   <= bus.smiRespData[63:32];
          rResp   <= err ? 2'b10 : status;
          rLast   <= finalBeat;
          beatCnt <= beatCnt + 8'd1;
          if (finalBeat) state <= frameEnd ? RSP_LAST : DRAIN;
          else if (frameEnd) state <= RSP_PAD;
        end
        // A truncated frame still owes the master the full burst length.
        RSP_PAD: if (rFree) begin
          rValid  <= 1'b1;
          rId     <= idReg;
          rData   <= 64'd0;
          rResp   <= 2'b10;
          rLast   <= finalBeat;
          beatCnt <= beatCnt + 8'd1;
          if (finalBeat) state <= RSP_LAST;
        end
        RSP_LAST: if (rFree) begin
          arReady <= 1'b1;
          state   <= IDLE;
        end
        DRAIN: if (respFire && frameEnd) begin
          if (rFree) begin
            arReady <= 1'b1;
            state   <= IDLE;
          end else begin
            state <= RSP_LAST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.axiARReady  = arReady;
  assign bus.smiReqReady = reqReady;
  assign bus.smiReqEofc  = reqEofc;
  assign bus.smiReqData  = reqData;
  assign bus.smiRespStop = respStop;
  assign bus.axiRValid   = rValid;
  assign bus.axiRId      = rId;
  assign bus.axiRData    = rData;
  assign bus.axiRResp    = rResp;
  assign bus.axiRLast    = rLast;

endmodule
